// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding and default CRC-16/CCITT constants for the CRC engine.
package crc_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_e;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/crc_engine_if.sv
// crc_engine_if: request/byte-stream/result bundle between a message source and the CRC engine.
interface crc_engine_if;
  logic start;
  logic [7:0] len;
  logic [7:0] din;
  logic din_vld;
  logic din_rdy;
  logic busy;
  logic done;
  logic [15:0] crc;
  modport master(output start, len, din, din_vld, input din_rdy, busy, done, crc);
  modport slave(input start, len, din, din_vld, output din_rdy, busy, done, crc);
endinterface

// File: rtl/crc_step.sv
// crc_step: one MSB-first CRC-16 bit update, purely combinational.
module crc_step
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY
) (
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);
  always_comb crc_o = {crc_i[14:0], 1'b0} ^ ((crc_i[15] ^ bit_i) ? POLY : 16'h0);
endmodule

// File: rtl/crc_engine.sv
// crc_engine: byte-streamed bit-serial CRC-16, one message bit per cycle, result held until next completion.
module crc_engine
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY,
  parameter logic [15:0] INIT = CRC_INIT
) (
  input logic        clk,
  input logic        rst_n,
  crc_engine_if.slave bus
);
  state_e      state_q, state_d;
  logic [7:0]  rem_q, sr_q;
  logic [2:0]  bit_q;
  logic [15:0] crc_reg_q, crc_q, step;
  logic        done_q, busy_q, rdy_q;
  crc_step #(.POLY(POLY)) u_step (.crc_i(crc_reg_q), .bit_i(sr_q[7]), .crc_o(step));
  always_comb
    state_d = (state_q == IDLE)      ? (bus.start ? ((bus.len == 8'd0) ? DONE : WAIT_BYTE) : IDLE) :
              (state_q == WAIT_BYTE) ? (bus.din_vld ? SHIFT : WAIT_BYTE) :
              (state_q == SHIFT)     ? ((bit_q != 3'd0) ? SHIFT : ((rem_q == 8'd1) ? DONE : WAIT_BYTE)) :
                                       IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= 8'd0;
      sr_q      <= 8'd0;
      bit_q     <= 3'd0;
      crc_reg_q <= 16'h0;
      crc_q     <= 16'h0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_d == DONE;
      busy_q  <= state_d != IDLE;
      rdy_q   <= state_d == WAIT_BYTE;
      if (state_q == IDLE && bus.start) begin
        rem_q     <= bus.len;
        crc_reg_q <= INIT;
      end
      if (state_q == WAIT_BYTE && bus.din_vld) begin
        sr_q  <= bus.din;
        bit_q <= 3'd7;
      end
      if (state_q == SHIFT) begin
        crc_reg_q <= step;
        sr_q      <= {sr_q[6:0], 1'b0};
        bit_q     <= bit_q - 3'd1;
        if (bit_q == 3'd0) rem_q <= rem_q - 8'd1;
      end
      // DONE is only entered from IDLE (empty message) or the final shift
      if (state_d == DONE) crc_q <= (state_q == SHIFT) ? step : INIT;
    end
  end
  assign bus.din_rdy = rdy_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.crc     = crc_q;
endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: message-level CRC model with per-cycle output checks, directed latency/result cases and random messages.
module tb_crc_engine;
  import crc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  crc_engine_if bus();
  crc_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rdy_seen;
  logic [7:0] msg[$];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) c = (c << 1) ^ ((c[15] ^ b[i]) ? CRC_POLY : 16'h0);
    return c;
  endfunction

  function automatic logic [15:0] crc_msg();
    logic [15:0] c = CRC_INIT;
    foreach (msg[i]) c = crc_byte(c, msg[i]);
    return c;
  endfunction

  // Message-level expectation: engine is ready from m_rdy_from, each byte costs 9 cycles
  bit m_act, m_wait;
  int m_left, m_rdy_from;
  int m_done_at = -1;
  logic [15:0] m_acc, m_crc;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_wait = 0; m_done_at = -1; m_crc = 16'h0;
      check("rst_busy", bus.busy, 0);
      check("rst_rdy", bus.din_rdy, 0);
      check("rst_done", bus.done, 0);
      check("rst_crc", bus.crc, 0);
    end else begin
      if (cyc == m_done_at) m_crc = m_acc;
      check("busy", bus.busy, m_act);
      check("din_rdy", bus.din_rdy, m_wait && cyc >= m_rdy_from);
      check("done", bus.done, cyc == m_done_at);
      check("crc", bus.crc, m_crc);
      if (cyc == m_done_at) begin
        m_act = 0; m_done_at = -1;
      end else if (!m_act) begin
        if (bus.start) begin
          m_act = 1; m_acc = CRC_INIT;
          if (bus.len == 8'd0) m_done_at = cyc + 1;
          else begin m_left = bus.len; m_wait = 1; m_rdy_from = cyc + 1; end
        end
      end else if (m_wait && cyc >= m_rdy_from && bus.din_vld) begin
        m_acc = crc_byte(m_acc, bus.din);
        m_left--;
        if (m_left == 0) begin m_wait = 0; m_done_at = cyc + 9; end
        else m_rdy_from = cyc + 9;
      end
    end
  end

  task automatic send(input int n, input int stall_byte, input int stall_n, input bit rnd,
                      input int extra_at, input int rst_at, output int lat);
    int s, idx, stalled;
    bit hs;
    idx = 0; stalled = 0; lat = -1; rdy_seen = 0;
    @(posedge clk); #1;
    s = cyc;
    bus.start = 1'b1;
    bus.len = n[7:0];
    bus.din = (msg.size() > 0) ? msg[0] : 8'h0;
    bus.din_vld = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      hs = bus.din_vld && bus.din_rdy;
      rdy_seen |= bus.din_rdy;
      if (bus.done) begin lat = cyc - s; break; end
      @(posedge clk); #1;
      if (cyc - s == rst_at) begin
        rst_n = 1'b0; bus.start = 1'b0; bus.din_vld = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_rdy", bus.din_rdy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_crc", bus.crc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = -2;
        break;
      end
      bus.start = (cyc - s == extra_at);
      if (hs) idx++;
      bus.din = (idx < msg.size()) ? msg[idx] : 8'h0;
      if (idx == stall_byte && bus.din_rdy && stalled < stall_n) begin
        bus.din_vld = 1'b0; stalled++;
      end else bus.din_vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.din_vld = 1'b0;
    if (lat == -1) begin
      tests++; fails++;
      $display("FAIL timeout: no done within cycle budget, got none, expected a done pulse");
    end
  endtask

  task automatic load_digits();
    msg = {};
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    int lat, n;
    bus.start = 0; bus.len = 0; bus.din = 0; bus.din_vld = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load_digits();
    check("model_digits", crc_msg(), 16'h29B1);
    msg = {8'h41};
    check("model_A", crc_msg(), 16'hB915);

    load_digits();
    send(9, -1, 0, 0, -1, -1, lat);
    check("lat_digits", lat, 82);
    check("crc_digits", bus.crc, 16'h29B1);

    msg = {};
    send(0, -1, 0, 0, -1, -1, lat);
    check("lat_len0", lat, 1);
    check("crc_len0", bus.crc, 16'hFFFF);
    check("rdy_len0", rdy_seen, 0);

    load_digits();
    send(9, 3, 5, 0, -1, -1, lat);
    check("lat_stall", lat, 87);
    check("crc_stall", bus.crc, 16'h29B1);

    send(9, -1, 0, 0, 14, -1, lat);
    check("lat_restart", lat, 82);
    check("crc_restart", bus.crc, 16'h29B1);

    send(9, -1, 0, 0, -1, 40, lat);
    check("rst_aborted", lat, -2);
    repeat (4) @(posedge clk);
    #1 check("crc_after_rst", bus.crc, 0);
    send(9, -1, 0, 0, -1, -1, lat);
    check("lat_rerun", lat, 82);
    check("crc_rerun", bus.crc, 16'h29B1);

    msg = {};
    for (int i = 0; i < 255; i++) msg.push_back(8'h00);
    send(255, -1, 0, 0, -1, -1, lat);
    check("lat_255", lat, 2296);
    check("crc_255", bus.crc, crc_msg());

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, 24);
      msg = {};
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      send(n, -1, 0, 1, -1, -1, lat);
      check("crc_rand", bus.crc, crc_msg());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
